// File: rtl/gated_bus_pkg.sv
// Shared definitions for the gated bus arbiter: default sizes, round-robin pick and one-hot decode.
// Latency: pure combinational helpers, no state.
// Backpressure: not applicable (no handshake in this package).
package gated_bus_pkg;

   localparam int DEF_WIDTH    = 16;
   localparam int DEF_CHANNELS = 4;
   // Helpers work on the largest supported channel count; callers zero-extend.
   localparam int MAX_CH       = 16;
   localparam int MAX_IDX_W    = 4;

   // One-hot grant: scan valid starting at ptr, wrapping modulo n; first set bit wins.
   // Requires ptr < n. Returns zero when no request is present.
   function automatic logic [MAX_CH-1:0] rr_pick(input logic [MAX_CH-1:0]    valid,
                                                  input logic [MAX_IDX_W-1:0] ptr,
                                                  input int                   n);
      logic [MAX_CH-1:0]  g;
      logic               found;
      logic [MAX_IDX_W:0] sum;
      g     = '0;
      found = 1'b0;
      for (int k = 0; k < MAX_CH; k++) begin
         if (k < n) begin
            // ptr + k never exceeds 2n-2, so a single conditional subtract is a full modulo.
            sum = {1'b0, ptr} + (MAX_IDX_W+1)'(k);
            if (sum >= (MAX_IDX_W+1)'(n)) begin
               sum = sum - (MAX_IDX_W+1)'(n);
            end
            if (!found && valid[sum[MAX_IDX_W-1:0]]) begin
               g[sum[MAX_IDX_W-1:0]] = 1'b1;
               found                 = 1'b1;
            end
         end
      end
      return g;
   endfunction

   // OR of the indices of all set bits; exact for one-hot or zero input, no priority chain.
   function automatic logic [MAX_IDX_W-1:0] onehot_to_idx(input logic [MAX_CH-1:0] oh);
      logic [MAX_IDX_W-1:0] r;
      r = '0;
      for (int i = 0; i < MAX_CH; i++) begin
         if (oh[i]) begin
            r = r | MAX_IDX_W'(i);
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/and_bus_gate.sv
// WIDTH-bit AND of a bus with a scalar enable (one gate per bit).
// Latency: combinational, zero cycles.
// Backpressure: none; output follows inputs.
// Ports: bus_in (WIDTH) source bus, en (1) enable, bus_out (WIDTH) gated bus.
module and_bus_gate #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] bus_in,
   input  logic             en,
   output logic [WIDTH-1:0] bus_out
);

   for (genvar b = 0; b < WIDTH; b++) begin : g_bit
      assign bus_out[b] = bus_in[b] & en;
   end

endmodule

// File: rtl/gated_bus_arbiter.sv
// Round-robin arbiter gating CHANNELS source buses onto one registered shared bus via AND/OR.
// Latency: 1 cycle from accepted input to OUT_VALID; 1 word/cycle while OUT_READY=1.
// Backpressure: OUT_READY low with a word held drops all IN_READY; consume and reload overlap.
// Ports: CLK, RST_N (async active-low); IN_DATA/IN_VALID/IN_READY per-channel sources;
//        OUT_DATA/OUT_SRC/OUT_VALID/OUT_READY registered output; LOCK only with the macro.
// Optional: define GATED_BUS_ARBITER_LOCK_EN to add LOCK (re-grant the same channel).
module gated_bus_arbiter
   import gated_bus_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int CHANNELS = DEF_CHANNELS,
   parameter int IDX_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                      CLK,
   input  logic                      RST_N,
   input  logic [CHANNELS*WIDTH-1:0] IN_DATA,
   input  logic [CHANNELS-1:0]       IN_VALID,
   output logic [CHANNELS-1:0]       IN_READY,
   output logic [WIDTH-1:0]          OUT_DATA,
   output logic [IDX_W-1:0]          OUT_SRC,
   output logic                      OUT_VALID,
`ifdef GATED_BUS_ARBITER_LOCK_EN
   input  logic                      LOCK,
`endif
   input  logic                      OUT_READY
);

   logic [WIDTH-1:0]     out_data_q, out_data_d;
   logic [IDX_W-1:0]     out_src_q,  out_src_d;
   logic                 out_vld_q,  out_vld_d;
   logic [IDX_W-1:0]     ptr_q,      ptr_d;
`ifdef GATED_BUS_ARBITER_LOCK_EN
   logic                 lock_vld_q, lock_vld_d;
   logic [IDX_W-1:0]     lock_idx_q, lock_idx_d;
`endif

   logic [MAX_CH-1:0]    valid_ext;
   logic [MAX_CH-1:0]    grant_ext;
   logic [CHANNELS-1:0]  grant;
   logic [MAX_IDX_W-1:0] win_ext;
   logic [IDX_W-1:0]     winner;
   logic [IDX_W-1:0]     ptr_nxt;
   logic                 can_take;
   logic                 load;
   logic [WIDTH-1:0]     gated;
   logic [WIDTH-1:0]     gated_bus [CHANNELS];

   // Grant selection
   always_comb begin
      valid_ext = MAX_CH'(IN_VALID);
      grant_ext = rr_pick(valid_ext, MAX_IDX_W'(ptr_q), CHANNELS);
`ifdef GATED_BUS_ARBITER_LOCK_EN
      // A lock only holds while its channel keeps requesting; otherwise fall back to the pointer.
      if (lock_vld_q && IN_VALID[lock_idx_q]) begin
         grant_ext = MAX_CH'(1) << lock_idx_q;
      end
`endif
      grant   = CHANNELS'(grant_ext);
      win_ext = onehot_to_idx(grant_ext);
      winner  = IDX_W'(win_ext);
      // Explicit wrap keeps the pointer below CHANNELS for non power-of-two counts.
      ptr_nxt = (winner == IDX_W'(CHANNELS-1)) ? '0 : winner + 1'b1;
   end

   assign can_take = ~out_vld_q | OUT_READY;
   assign load     = (|IN_VALID) & can_take;
   // Qualified with RST_N so no source sees an accept while reset is asserted.
   assign IN_READY = grant & {CHANNELS{can_take & RST_N}};

   // Data path: per-channel AND gate, then a plain OR tree.
   for (genvar g = 0; g < CHANNELS; g++) begin : g_gate
      and_bus_gate #(
         .WIDTH (WIDTH)
      ) u_gate (
         .bus_in  (IN_DATA[g*WIDTH +: WIDTH]),
         .en      (grant[g]),
         .bus_out (gated_bus[g])
      );
   end

   always_comb begin
      gated = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         gated = gated | gated_bus[i];
      end
   end

   // Output stage and pointer next-state
   always_comb begin
      out_data_d = out_data_q;
      out_src_d  = out_src_q;
      out_vld_d  = out_vld_q;
      ptr_d      = ptr_q;
`ifdef GATED_BUS_ARBITER_LOCK_EN
      lock_vld_d = lock_vld_q;
      lock_idx_d = lock_idx_q;
`endif
      if (load) begin
         // A new load wins over a simultaneous consume, so there is no bubble.
         out_data_d = gated;
         out_src_d  = winner;
         out_vld_d  = 1'b1;
`ifdef GATED_BUS_ARBITER_LOCK_EN
         lock_vld_d = LOCK;
         lock_idx_d = winner;
         // Pointer freezes during a locked load so round-robin resumes from where it stood.
         if (!LOCK) begin
            ptr_d = ptr_nxt;
         end
`else
         ptr_d = ptr_nxt;
`endif
      end else if (out_vld_q && OUT_READY) begin
         out_vld_d = 1'b0;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         out_data_q <= '0;
         out_src_q  <= '0;
         out_vld_q  <= 1'b0;
         ptr_q      <= '0;
`ifdef GATED_BUS_ARBITER_LOCK_EN
         lock_vld_q <= 1'b0;
         lock_idx_q <= '0;
`endif
      end else begin
         out_data_q <= out_data_d;
         out_src_q  <= out_src_d;
         out_vld_q  <= out_vld_d;
         ptr_q      <= ptr_d;
`ifdef GATED_BUS_ARBITER_LOCK_EN
         lock_vld_q <= lock_vld_d;
         lock_idx_q <= lock_idx_d;
`endif
      end
   end

   assign OUT_DATA  = out_data_q;
   assign OUT_SRC   = out_src_q;
   assign OUT_VALID = out_vld_q;

endmodule
